rsfq_gate_clocked_n: RTL and testbench
======================================

Name: rsfq_gate_clocked_n

Overview:
- Synthesizable, parametrised successor to the two-input clocked SFQ OR behavioural cell.
- Emulates an N-input clocked RSFQ gate on a conventional synchronous clock.
- SFQ pulses on data inputs, SFQ clock and output are toggle-encoded: each level transition is one pulse.
- Adds selectable OR/AND/XOR evaluation, a startup blanking window, hold-window violation detection and per-input arm status. Used in FPGA-hosted RSFQ netlist emulation and in co-simulation against timed cell models.

Parameters:
- N_IN, 2, number of data inputs (2..16).
- MODE, 0, evaluation rule: 0 = OR (any input armed), 1 = AND (all armed), 2 = XOR (exactly one armed).
- HOLD_CYC, 1, hold window in clk cycles after an SFQ clock pulse (0 disables the check).
- INIT_CYC, 8, clk cycles after reset during which all pulses are ignored (startup state undefined).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_tgl  in  N_IN  toggle-encoded SFQ data inputs.
- sclk_tgl  in  1  toggle-encoded SFQ clock.
- q_tgl  out  1  toggle-encoded SFQ output.
- q_pulse  out  1  one-cycle strobe, coincident with each q_tgl transition.
- armed  out  N_IN  per-input armed state.
- viol  out  1  one-cycle strobe marking a hold-window violation.
- ready  out  1  high once the blanking window has expired.

Behaviour:
- Pulse detection:
  - Registered copies prev_in and prev_sclk are kept.
  - pulse_i = in_tgl[i] ^ prev_in[i]; spulse = sclk_tgl ^ prev_sclk.
  - prev registers update every cycle, including during blanking, so pulses are not replayed at the end of blanking.
- Reset (rst=1 at an edge):
  - q_tgl=0, q_pulse=0, armed=0, viol=0, ready=0.
  - Blank counter loads INIT_CYC; hold counter cleared.
  - prev_in and prev_sclk are loaded with the current inputs, so no pulse is detected on the first cycle after reset.
  - Reset mid-operation discards all armed state and any pending output.
- Blanking:
  - The counter decrements each cycle; ready rises at the edge where it reaches 0.
  - While ready=0, all pulses are ignored and viol is never asserted.
- State machine: BLANK -> IDLE (armed==0) <-> ARMED (armed!=0). ARMED -> IDLE on an SFQ clock.
- Data pulse (ready=1): armed[i] is set at that edge. A duplicate pulse on an already-armed input has no effect (idempotent, as in the cell).
- SFQ clock pulse at edge k (ready=1):
  - Evaluate the rule on eff = armed | pulse, i.e. same-edge data counts as before the clock.
  - If the rule is true: q_tgl toggles and q_pulse=1 at edge k+1 (one-cycle latency).
  - armed clears to 0 at edge k regardless of the result.
  - Hold counter loads HOLD_CYC.
- Hold check:
  - The hold counter decrements to 0 each cycle.
  - viol=1 at the next edge if any data pulse is sampled while hold_cnt!=0.
  - viol=1 also for any data pulse coincident with spulse when HOLD_CYC>0.
  - The violating pulse is still recorded normally: it arms for the next period, or contributes at the coincident edge.
- No input pulses at a clock: no output; the clock is still consumed.
- Consecutive SFQ clocks: each evaluates independently; q_pulse may assert on consecutive cycles.
- Width: hold_cnt and blank_cnt are sized $clog2(max+1); no wrap, both saturate at 0.

Optional Feature:
- Macro RSFQ_GATE_STATS_EN.
- When defined, adds outputs fire_cnt[15:0] and viol_cnt[15:0]:
  - Incremented with each q_pulse and viol respectively.
  - Saturate at 16'hFFFF; cleared by rst.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package rsfq_emu_pkg holds:
  - enum gate_mode_e {GM_OR, GM_AND, GM_XOR};
  - state enum {ST_BLANK, ST_IDLE, ST_ARMED};
  - constant STAT_W = 16.
- Sub-module rsfq_tgl_edge: parametrised width; holds the prev register and pulse XOR, and is reused for data and the SFQ clock.

Test Plan:
- Reset, INIT_CYC=8, toggle in_tgl[0] at cycle 3 -> ready rises at cycle 8, armed stays 0, no q_pulse, no viol.
- MODE=0, N_IN=4: pulse in[2], then sclk 3 cycles later -> q_tgl 0->1 with q_pulse one cycle after the sclk edge, armed returns to 0.
- MODE=1, N_IN=3: pulse in[0] and in[1], sclk -> no output. Then pulse all three, sclk -> one q_pulse.
- MODE=2: pulse in[0] twice plus in[1], sclk -> no output (two armed). Pulse only in[1], sclk -> q_pulse.
- HOLD_CYC=2: sclk at cycle 20, pulse in[0] at cycle 21 -> viol at 22, armed[0]=1. Next sclk -> q_pulse.
- Data and sclk toggled on the same edge (HOLD_CYC=1) -> q_pulse next cycle and viol=1. With RSFQ_GATE_STATS_EN: fire_cnt=1, viol_cnt=1. Assert rst while armed -> all cleared, counters 0.

Source files
------------

// File: rtl/rsfq_emu_pkg.sv
// Shared types and helpers for the clocked RSFQ gate emulation blocks.
package rsfq_emu_pkg;

  typedef enum logic [1:0] {GM_OR, GM_AND, GM_XOR} gate_mode_e;

  typedef enum logic [1:0] {ST_BLANK, ST_IDLE, ST_ARMED} gate_state_e;

  localparam int STAT_W = 16;
  localparam int MAX_IN = 16;

  // Counter width for a down-counter that must hold max_val; never narrower than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

  function automatic logic gate_eval(input gate_mode_e mode,
                                     input logic [MAX_IN-1:0] eff,
                                     input logic [MAX_IN-1:0] mask);
    logic res;
    case (mode)
      GM_AND:  res = ((eff & mask) == mask);
      GM_XOR:  res = ($countones(eff & mask) == 1);
      default: res = |(eff & mask);
    endcase
    return res;
  endfunction

endpackage

// File: rtl/rsfq_tgl_edge.sv
// Toggle-to-pulse converter: one-cycle pulse on every level change of each bit.
module rsfq_tgl_edge #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic [W-1:0] tgl,
  output logic [W-1:0] pulse
);

  logic [W-1:0] prev;

  // Tracking the input every cycle (reset included) means a level change is never replayed later.
  always_ff @(posedge clk) begin
    prev <= tgl;
  end

  assign pulse = tgl ^ prev;

endmodule

// File: rtl/rsfq_gate_clocked_n.sv
// N-input clocked RSFQ gate emulated on clk, with OR/AND/XOR rule, startup blanking and hold check.
// Optional pulse/violation counters are built when RSFQ_GATE_STATS_EN is defined.
//
// state    | meaning
// ST_BLANK | startup window after reset, every pulse ignored
// ST_IDLE  | running, no input armed
// ST_ARMED | running, at least one input armed, waiting for SFQ clock
module rsfq_gate_clocked_n
  import rsfq_emu_pkg::*;
#(
  parameter int N_IN     = 2,
  parameter int MODE     = 0,
  parameter int HOLD_CYC = 1,
  parameter int INIT_CYC = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_IN-1:0] in_tgl,
  input  logic            sclk_tgl,
  output logic            q_tgl,
  output logic            q_pulse,
  output logic [N_IN-1:0] armed,
  output logic            viol,
  output logic            ready
`ifdef RSFQ_GATE_STATS_EN
  ,
  output logic [STAT_W-1:0] fire_cnt,
  output logic [STAT_W-1:0] viol_cnt
`endif
);

  localparam int HW = cnt_w(HOLD_CYC);
  localparam int BW = cnt_w(INIT_CYC);
  localparam logic [HW-1:0]     HOLD_LD = HOLD_CYC[HW-1:0];
  localparam logic [BW-1:0]     INIT_LD = INIT_CYC[BW-1:0];
  localparam gate_mode_e        GMODE   = gate_mode_e'(MODE[1:0]);
  localparam logic [MAX_IN-1:0] IN_MASK = MAX_IN'({N_IN{1'b1}});
  localparam logic              HOLD_EN = (HOLD_CYC > 0);

  gate_state_e state, state_nxt;

  logic [N_IN-1:0]   pulse;
  logic              spulse;
  logic [N_IN-1:0]   eff;
  logic [N_IN-1:0]   armed_nxt;
  logic [MAX_IN-1:0] eff_ext;
  logic [BW-1:0]     blank_cnt;
  logic [HW-1:0]     hold_cnt;
  logic              active;
  logic              fire_now;
  logic              viol_now;
  logic              fire_pend;
  logic              viol_pend;

  rsfq_tgl_edge #(.W(N_IN)) u_in_edge (
    .clk   (clk),
    .tgl   (in_tgl),
    .pulse (pulse)
  );

  rsfq_tgl_edge #(.W(1)) u_sclk_edge (
    .clk   (clk),
    .tgl   (sclk_tgl),
    .pulse (spulse)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_BLANK;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_BLANK: begin
        if (blank_cnt <= BW'(1)) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_IDLE, ST_ARMED: begin
        state_nxt = (armed_nxt != '0) ? ST_ARMED : ST_IDLE;
      end
      default: state_nxt = ST_BLANK;
    endcase
  end

  // Same-edge data counts as arriving before the clock: evaluate on armed | pulse.
  always_comb begin
    active    = (state != ST_BLANK);
    eff       = armed | pulse;
    eff_ext   = MAX_IN'(eff);
    armed_nxt = armed;
    fire_now  = 1'b0;
    viol_now  = 1'b0;
    if (active) begin
      armed_nxt = spulse ? '0 : eff;
      fire_now  = spulse && gate_eval(GMODE, eff_ext, IN_MASK);
      viol_now  = (|pulse) && ((hold_cnt != '0) || (spulse && HOLD_EN));
    end
  end

  assign ready = (state != ST_BLANK);

  always_ff @(posedge clk) begin
    if (rst) begin
      armed     <= '0;
      blank_cnt <= INIT_LD;
      hold_cnt  <= '0;
      fire_pend <= 1'b0;
      viol_pend <= 1'b0;
      q_tgl     <= 1'b0;
      q_pulse   <= 1'b0;
      viol      <= 1'b0;
    end else begin
      armed <= armed_nxt;
      if (blank_cnt != '0) begin
        blank_cnt <= blank_cnt - BW'(1);
      end
      if (active && spulse) begin
        hold_cnt <= HOLD_LD;
      end else if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HW'(1);
      end
      fire_pend <= fire_now;
      viol_pend <= viol_now;
      q_pulse   <= fire_pend;
      viol      <= viol_pend;
      if (fire_pend) begin
        q_tgl <= ~q_tgl;
      end
    end
  end

`ifdef RSFQ_GATE_STATS_EN
  // Counters step on the same edge their strobe rises and stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      fire_cnt <= '0;
      viol_cnt <= '0;
    end else begin
      if (fire_pend && (fire_cnt != '1)) begin
        fire_cnt <= fire_cnt + STAT_W'(1);
      end
      if (viol_pend && (viol_cnt != '1)) begin
        viol_cnt <= viol_cnt + STAT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_rsfq_gate_clocked_n.sv
// Bench for rsfq_gate_clocked_n: three configurations (OR/AND/XOR) share one stimulus stream.
module tb_rsfq_gate_clocked_n;

  localparam int ND = 3;

  function automatic int p_n(input int d);
    return (d == 1) ? 3 : 4;
  endfunction
  function automatic int p_mode(input int d);
    return d;
  endfunction
  function automatic int p_hold(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 0);
  endfunction
  function automatic int p_init(input int d);
    return (d == 2) ? 5 : 8;
  endfunction

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] in_r = '0;
  logic       s_r = 1'b0;

  logic [2:0] q_tgl_v, q_pulse_v, viol_v, ready_v;
  logic [3:0] armed0, armed2;
  logic [2:0] armed1;
`ifdef RSFQ_GATE_STATS_EN
  logic [15:0] fc0, fc1, fc2, vc0, vc1, vc2;
`endif

  rsfq_gate_clocked_n #(.N_IN(4), .MODE(0), .HOLD_CYC(2), .INIT_CYC(8)) u_or (
    .clk(clk), .rst(rst), .in_tgl(in_r), .sclk_tgl(s_r),
    .q_tgl(q_tgl_v[0]), .q_pulse(q_pulse_v[0]), .armed(armed0),
    .viol(viol_v[0]), .ready(ready_v[0])
`ifdef RSFQ_GATE_STATS_EN
    , .fire_cnt(fc0), .viol_cnt(vc0)
`endif
  );

  rsfq_gate_clocked_n #(.N_IN(3), .MODE(1), .HOLD_CYC(1), .INIT_CYC(8)) u_and (
    .clk(clk), .rst(rst), .in_tgl(in_r[2:0]), .sclk_tgl(s_r),
    .q_tgl(q_tgl_v[1]), .q_pulse(q_pulse_v[1]), .armed(armed1),
    .viol(viol_v[1]), .ready(ready_v[1])
`ifdef RSFQ_GATE_STATS_EN
    , .fire_cnt(fc1), .viol_cnt(vc1)
`endif
  );

  rsfq_gate_clocked_n #(.N_IN(4), .MODE(2), .HOLD_CYC(0), .INIT_CYC(5)) u_xor (
    .clk(clk), .rst(rst), .in_tgl(in_r), .sclk_tgl(s_r),
    .q_tgl(q_tgl_v[2]), .q_pulse(q_pulse_v[2]), .armed(armed2),
    .viol(viol_v[2]), .ready(ready_v[2])
`ifdef RSFQ_GATE_STATS_EN
    , .fire_cnt(fc2), .viol_cnt(vc2)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int e = 0;

  // Reference model: sets of armed inputs, distance to the last SFQ clock, a queue-like pending slot.
  logic [3:0] m_prev = '0;
  bit         m_prev_s = 1'b0;
  int         m_since[ND];
  int         m_last[ND];
  logic [3:0] m_armed[ND];
  bit         m_pf[ND], m_pv[ND], m_qp[ND], m_viol[ND], m_q[ND];
  int         m_fc[ND], m_vc[ND];

  task automatic chk(input string name, input int d, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d edge %0d: got %0d expected %0d", name, d, e, act, exp);
    end
  endtask

  function automatic int get_armed(input int d);
    case (d)
      0:       return int'(armed0);
      1:       return int'(armed1);
      default: return int'(armed2);
    endcase
  endfunction

  task automatic model_edge(input bit r, input logic [3:0] x, input bit s);
    logic [3:0] p, pd, eff, mask;
    bit sp, rdy, fire;
    int n;
    e++;
    p = x ^ m_prev;
    sp = s ^ m_prev_s;
    m_prev = x;
    m_prev_s = s;
    for (int d = 0; d < ND; d++) begin
      mask = 4'((1 << p_n(d)) - 1);
      if (r) begin
        m_since[d] = 0; m_armed[d] = '0; m_pf[d] = 0; m_pv[d] = 0;
        m_qp[d] = 0; m_viol[d] = 0; m_q[d] = 0; m_last[d] = -1000;
        m_fc[d] = 0; m_vc[d] = 0;
      end else begin
        m_qp[d] = m_pf[d];
        m_viol[d] = m_pv[d];
        if (m_qp[d]) begin
          m_q[d] = !m_q[d];
          if (m_fc[d] < 65535) m_fc[d]++;
        end
        if (m_viol[d] && m_vc[d] < 65535) m_vc[d]++;
        rdy = (m_since[d] >= p_init(d));
        if (!rdy) m_since[d]++;
        m_pf[d] = 0;
        m_pv[d] = 0;
        if (rdy) begin
          pd = p & mask;
          eff = m_armed[d] | pd;
          n = $countones(eff);
          m_pv[d] = (pd != 0) && (p_hold(d) > 0) && (sp || (e - m_last[d]) <= p_hold(d));
          if (sp) begin
            case (p_mode(d))
              0:       fire = (n > 0);
              1:       fire = (n == p_n(d));
              default: fire = (n == 1);
            endcase
            m_pf[d] = fire;
            m_armed[d] = '0;
            m_last[d] = e;
          end else begin
            m_armed[d] = eff;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < ND; d++) begin
      chk("q_tgl", d, int'(q_tgl_v[d]), int'(m_q[d]));
      chk("q_pulse", d, int'(q_pulse_v[d]), int'(m_qp[d]));
      chk("viol", d, int'(viol_v[d]), int'(m_viol[d]));
      chk("armed", d, get_armed(d), int'(m_armed[d]));
      chk("ready", d, int'(ready_v[d]), (m_since[d] >= p_init(d)) ? 1 : 0);
    end
`ifdef RSFQ_GATE_STATS_EN
    chk("fire_cnt", 0, int'(fc0), m_fc[0]);
    chk("fire_cnt", 1, int'(fc1), m_fc[1]);
    chk("fire_cnt", 2, int'(fc2), m_fc[2]);
    chk("viol_cnt", 0, int'(vc0), m_vc[0]);
    chk("viol_cnt", 1, int'(vc1), m_vc[1]);
    chk("viol_cnt", 2, int'(vc2), m_vc[2]);
`endif
  endtask

  task automatic step(input bit r, input logic [3:0] tin, input bit ts);
    @(negedge clk);
    rst = r;
    in_r = in_r ^ tin;
    s_r = s_r ^ ts;
    @(posedge clk);
    #1;
    model_edge(r, in_r, s_r);
    check_all();
  endtask

  typedef struct {
    bit         r;
    logic [3:0] tin;
    bit         ts;
    bit         rdy;
    bit         qp;
    bit         vl;
    logic [3:0] arm;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, input logic [3:0] tin, input bit ts,
                     input bit rdy, input bit qp, input bit vl, input logic [3:0] arm);
    vec_t v;
    v.r = r; v.tin = tin; v.ts = ts; v.rdy = rdy; v.qp = qp; v.vl = vl; v.arm = arm;
    tbl.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Hand-derived expectations for the OR gate (N_IN=4, HOLD_CYC=2, INIT_CYC=8); row i is edge i.
    add(1, 4'h0, 0, 0, 0, 0, 4'h0);
    add(0, 4'h0, 0, 0, 0, 0, 4'h0);
    add(0, 4'h0, 0, 0, 0, 0, 4'h0);
    add(0, 4'h1, 0, 0, 0, 0, 4'h0);
    add(0, 4'h0, 0, 0, 0, 0, 4'h0);
    add(0, 4'h0, 0, 0, 0, 0, 4'h0);
    add(0, 4'h0, 0, 0, 0, 0, 4'h0);
    add(0, 4'h0, 0, 0, 0, 0, 4'h0);
    add(0, 4'h0, 0, 1, 0, 0, 4'h0);
    add(0, 4'h4, 0, 1, 0, 0, 4'h4);
    add(0, 4'h0, 0, 1, 0, 0, 4'h4);
    add(0, 4'h0, 0, 1, 0, 0, 4'h4);
    add(0, 4'h0, 1, 1, 0, 0, 4'h0);
    add(0, 4'h0, 0, 1, 1, 0, 4'h0);
    add(0, 4'h1, 0, 1, 0, 0, 4'h1);
    add(0, 4'h0, 0, 1, 0, 1, 4'h1);
    add(0, 4'h0, 1, 1, 0, 0, 4'h0);
    add(0, 4'h0, 0, 1, 1, 0, 4'h0);
    add(0, 4'h2, 1, 1, 0, 0, 4'h0);
    add(0, 4'h0, 0, 1, 1, 1, 4'h0);
    add(0, 4'h0, 1, 1, 0, 0, 4'h0);
    add(0, 4'h8, 0, 1, 0, 0, 4'h8);
    add(0, 4'h0, 1, 1, 0, 1, 4'h0);
    add(0, 4'h1, 1, 1, 1, 0, 4'h0);
    add(0, 4'h0, 0, 1, 1, 1, 4'h0);
    add(0, 4'h4, 0, 1, 0, 0, 4'h4);
    add(0, 4'h0, 0, 1, 0, 1, 4'h4);
    add(1, 4'h0, 0, 0, 0, 0, 4'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].tin, tbl[i].ts);
      chk("tbl_ready", 0, int'(ready_v[0]), int'(tbl[i].rdy));
      chk("tbl_q_pulse", 0, int'(q_pulse_v[0]), int'(tbl[i].qp));
      chk("tbl_viol", 0, int'(viol_v[0]), int'(tbl[i].vl));
      chk("tbl_armed", 0, int'(armed0), int'(tbl[i].arm));
    end

    for (int i = 0; i < 9; i++) step(0, 4'h0, 0);

    // AND over three inputs: two armed is not enough, all three fires once.
    step(0, 4'h3, 0);
    step(0, 4'h0, 0);
    step(0, 4'h0, 1);
    step(0, 4'h0, 0);
    chk("and_partial", 1, int'(q_pulse_v[1]), 0);
    step(0, 4'h7, 0);
    step(0, 4'h0, 0);
    step(0, 4'h0, 1);
    step(0, 4'h0, 0);
    chk("and_full", 1, int'(q_pulse_v[1]), 1);

    // XOR: duplicate pulse on in[0] stays one armed input, plus in[1] makes two.
    step(0, 4'h1, 0);
    step(0, 4'h1, 0);
    step(0, 4'h2, 0);
    step(0, 4'h0, 1);
    step(0, 4'h0, 0);
    chk("xor_two", 2, int'(q_pulse_v[2]), 0);
    step(0, 4'h2, 0);
    step(0, 4'h0, 1);
    step(0, 4'h0, 0);
    chk("xor_one", 2, int'(q_pulse_v[2]), 1);

    // Coincident data and clock on the AND gate, then reset while armed.
    step(0, 4'h7, 1);
    step(0, 4'h0, 0);
    chk("coinc_q_pulse", 1, int'(q_pulse_v[1]), 1);
    chk("coinc_viol", 1, int'(viol_v[1]), 1);
    step(0, 4'h1, 0);
    step(1, 4'h0, 0);
    chk("rst_armed", 1, int'(armed1), 0);
    for (int i = 0; i < 9; i++) step(0, 4'h0, 0);

    for (int i = 0; i < 3000; i++) begin
      logic [3:0] t;
      t = '0;
      for (int b = 0; b < 4; b++) t[b] = ($urandom_range(0, 5) == 0);
      step($urandom_range(0, 299) == 0, t, $urandom_range(0, 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
